lat_data_mem: RTL and testbench
===============================

Name: lat_data_mem

Overview:
Parametrised, synthesizable data-memory model for the 16-bit pipelined processor; successor to the fixed one-cycle bench memory model. Adds configurable read latency with a valid strobe, periodic ready-low stall injection, and sticky error flags. Adds saturating access counters for result checking. Sits between the processor's dm port and the bench, or drives the im port in read-only use.

Parameters:
ADDR_WIDTH, 8, address width
DATA_WIDTH, 16, word width
DEPTH, 256, number of words; must be at most 2^ADDR_WIDTH
RD_LAT, 1, read latency in cycles; legal range 1..8
STALL_PERIOD, 16, stall-injection period in cycles; must be at least 2
STALL_LEN, 0, ready-low cycles per period; 0 disables stalls; must be less than STALL_PERIOD
CNT_WIDTH, 16, access-counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_rd  in  1  read request
req_wr  in  1  write request
req_addr  in  ADDR_WIDTH  word address
req_w_data  in  DATA_WIDTH  write data
ready  out  1  request accepted this cycle when high
r_data  out  DATA_WIDTH  read data, meaningful only while r_valid is high
r_valid  out  1  one-cycle strobe marking returned read data
rd_cnt  out  CNT_WIDTH  accepted reads, saturating
wr_cnt  out  CNT_WIDTH  accepted writes, saturating
err_conflict  out  1  sticky: req_rd and req_wr were high together while ready was high
err_range  out  1  sticky: an accepted access had req_addr >= DEPTH
clr_stat  in  1  synchronous clear of counters and error flags

Behaviour:
- Reset values: ready=1, r_valid=0, r_data=0, rd_cnt=0, wr_cnt=0, err_conflict=0, err_range=0, stall counter=0. Memory contents are NOT cleared.
- Reset mid-operation: all in-flight reads are dropped; no r_valid is produced for them.
- Acceptance: a request is accepted on a rising edge where ready=1 and (req_rd or req_wr) is high. While ready=0 the request is ignored and not counted. The requester holds its request until it is accepted.
- Write: mem[addr] <= req_w_data on the accepting edge. Single-cycle; no response is returned.
- Read:
  - The array is sampled on the accepting edge, so a read sees every write accepted on earlier edges.
  - The read enters a RD_LAT-deep valid/data shift pipeline.
  - r_valid=1 and r_data=word are visible from the edge at acceptance+RD_LAT, for exactly one cycle.
  - Back-to-back reads are fully pipelined: one accepted per cycle gives one r_valid per cycle, in order.
- r_data holds its last value when r_valid=0.
- Conflict: req_rd and req_wr both high while ready=1 → the write is performed and counted, the read is dropped (no r_valid), and err_conflict is set.
- Range: an accepted access with addr >= DEPTH sets err_range. Such a write is discarded; such a read returns 0 with a normal r_valid. The access is still counted.
- Stall injection:
  - A free-running counter cnt cycles 0..STALL_PERIOD-1 and wraps to 0.
  - ready = (STALL_LEN==0) or (cnt < STALL_PERIOD-STALL_LEN).
  - Reads already in the pipeline keep advancing during stall cycles.
- Counters saturate at 2^CNT_WIDTH-1; they do not wrap.
- clr_stat: zeroes the counters and error flags on the next edge. If an access is accepted on that same edge, the counter result is 1 (clear, then count). If an error occurs on that same edge, the flag is set.
- rst has priority over clr_stat.

Test Plan:
- RD_LAT=3, no stalls: write mem[5]=0x0007 at cycle t, read addr 5 at t+1 → r_valid high only at t+4 with r_data=0x0007; wr_cnt=1, rd_cnt=1.
- RD_LAT=2: reads of addr 0,1,2,3 on 4 consecutive cycles holding 0x10,0x11,0x12,0x13 → 4 consecutive r_valid pulses returning 0x10..0x13 in order.
- STALL_PERIOD=8, STALL_LEN=2: hold a read request continuously from reset → ready low at cnt 6,7 of every period; 6 reads accepted per 8 cycles; no r_valid lost.
- req_rd=req_wr=1, addr 9, data 0xBEEF → mem[9]=0xBEEF, no r_valid, err_conflict=1, wr_cnt=1, rd_cnt=0. Then clr_stat pulse → all four are 0.
- DEPTH=24: write addr 30 with 0x1234, then read addr 30 → err_range=1, r_data=0 with r_valid; mem[0..23] unchanged.
- CNT_WIDTH=4: 20 accepted reads → rd_cnt holds 15. Assert rst while 2 reads are in flight → no r_valid follows; all outputs return to reset values.

Source files
------------

// File: rtl/lat_data_mem_if.sv
// Request/response bus between a requester and lat_data_mem.
// The requester holds req_* until it sees ready high at a rising edge.
interface lat_data_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req_rd;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_w_data;
  logic                  ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  modport master (
    output req_rd, req_wr, req_addr, req_w_data,
    input  ready, r_data, r_valid
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_w_data,
    output ready, r_data, r_valid
  );
endinterface

// File: rtl/lat_data_mem.sv
// Data memory with RD_LAT-cycle pipelined reads, periodic ready-low stalls,
// saturating access counters and sticky conflict/range error flags.
module lat_data_mem #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int STALL_PERIOD = 16,
  parameter int STALL_LEN    = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lat_data_mem_if.slave        bus,
  input  logic                 clr_stat,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic [CNT_WIDTH-1:0] wr_cnt,
  output logic                 err_conflict,
  output logic                 err_range
);
  localparam int CW  = $clog2(STALL_PERIOD);
  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(STALL_PERIOD - 1);
  localparam logic [31:0]           RDY_LIM  = 32'(STALL_PERIOD - STALL_LEN);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);

  logic [CW-1:0]                       cnt;
  logic                                ready;
  logic                                acc, wr_acc, rd_acc, conflict, in_range;
  logic [AIW-1:0]                      idx;
  logic [DATA_WIDTH-1:0]               mem [DEPTH];
  logic [RD_LAT-1:0][DATA_WIDTH-1:0]   dat_pipe;
  logic [RD_LAT:0]                     vld_pipe;
  logic [DATA_WIDTH-1:0]               r_data_q;

  // Free-running stall phase; ready drops for the last STALL_LEN slots.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign ready    = (STALL_LEN == 0) || (32'(cnt) < RDY_LIM);
  assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
  assign idx      = bus.req_addr[AIW-1:0];
  assign acc      = ready & (bus.req_rd | bus.req_wr);
  assign conflict = ready & bus.req_rd & bus.req_wr;
  assign wr_acc   = acc & bus.req_wr;
  assign rd_acc   = acc & bus.req_rd & ~bus.req_wr;

  // A conflicting read is dropped, so a read never shares an edge with a write.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) mem[idx] <= bus.req_w_data;
    dat_pipe[0] <= in_range ? mem[idx] : '0;
    for (int i = 1; i < RD_LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
  end

  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 clr,
    input logic                 inc
  );
    logic [CNT_WIDTH-1:0] b;
    b = clr ? '0 : c;
    if (inc && !(&b)) b = b + 1'b1;
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      r_data_q     <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      err_conflict <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_acc};
      if (vld_pipe[RD_LAT-1]) r_data_q <= dat_pipe[RD_LAT-1];
      rd_cnt       <= cnt_next(rd_cnt, clr_stat, rd_acc);
      wr_cnt       <= cnt_next(wr_cnt, clr_stat, wr_acc);
      err_conflict <= (err_conflict & ~clr_stat) | conflict;
      err_range    <= (err_range & ~clr_stat) | (acc & ~in_range);
    end
  end

  assign bus.ready   = ready;
  assign bus.r_valid = vld_pipe[RD_LAT];
  assign bus.r_data  = r_data_q;
endmodule

// File: tb/tb_lat_data_mem.sv
// Randomized + directed bench for lat_data_mem: two configurations checked
// in turn against a queue-based reference model.
module tb_lat_data_mem;
  logic        clk = 1'b0;
  logic        rst, clr_stat;
  logic        req_rd, req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_w_data;

  always #5 clk = ~clk;

  lat_data_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_a ();
  lat_data_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_b ();
  assign bus_a.req_rd = req_rd;  assign bus_a.req_wr = req_wr;
  assign bus_a.req_addr = req_addr;  assign bus_a.req_w_data = req_w_data;
  assign bus_b.req_rd = req_rd;  assign bus_b.req_wr = req_wr;
  assign bus_b.req_addr = req_addr;  assign bus_b.req_w_data = req_w_data;

  logic [3:0]  rd_cnt_a, wr_cnt_a;
  logic [15:0] rd_cnt_b, wr_cnt_b;
  logic        ec_a, er_a, ec_b, er_b;

  lat_data_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(24), .RD_LAT(3),
    .STALL_PERIOD(16), .STALL_LEN(0), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a), .clr_stat(clr_stat),
    .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a), .err_conflict(ec_a), .err_range(er_a));

  lat_data_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .RD_LAT(2),
    .STALL_PERIOD(8), .STALL_LEN(2), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b), .clr_stat(clr_stat),
    .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b), .err_conflict(ec_b), .err_range(er_b));

  // Observed outputs of whichever instance is under test.
  int          sel;
  logic        o_ready, o_valid, o_ec, o_er;
  logic [15:0] o_data, o_rcnt, o_wcnt;
  always_comb begin
    o_ready = (sel == 0) ? bus_a.ready   : bus_b.ready;
    o_valid = (sel == 0) ? bus_a.r_valid : bus_b.r_valid;
    o_data  = (sel == 0) ? bus_a.r_data  : bus_b.r_data;
    o_rcnt  = (sel == 0) ? {12'b0, rd_cnt_a} : rd_cnt_b;
    o_wcnt  = (sel == 0) ? {12'b0, wr_cnt_a} : wr_cnt_b;
    o_ec    = (sel == 0) ? ec_a : ec_b;
    o_er    = (sel == 0) ? er_a : er_b;
  end

  // Reference model: config, memory image, in-flight responses with due edge.
  typedef struct { int due; logic [15:0] data; } rsp_t;
  int          p_lat, p_per, p_len, p_depth, p_cmax;
  logic [15:0] mmem [256];
  rsp_t        q[$];
  int          edge_no, cyc, m_rcnt, m_wcnt;
  bit          m_ec, m_er, m_valid, m_acc;
  logic [15:0] m_data;
  int          n_cmp, n_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (p_len == 0) || ((cyc % p_per) < (p_per - p_len));
  endfunction

  task automatic model_edge();
    bit rdy, inr;
    edge_no++;
    m_acc = 1'b0;
    if (rst) begin
      q.delete(); cyc = 0; m_rcnt = 0; m_wcnt = 0;
      m_ec = 0; m_er = 0; m_valid = 0; m_data = '0;
      return;
    end
    rdy   = m_ready();
    m_acc = rdy && (req_rd || req_wr);
    inr   = int'(req_addr) < p_depth;
    if (clr_stat) begin m_rcnt = 0; m_wcnt = 0; m_ec = 0; m_er = 0; end
    if (rdy && req_rd && req_wr) m_ec = 1;
    if (m_acc && !inr) m_er = 1;
    if (m_acc && req_wr) begin
      if (m_wcnt < p_cmax) m_wcnt++;
      if (inr) mmem[req_addr] = req_w_data;
    end else if (m_acc) begin
      if (m_rcnt < p_cmax) m_rcnt++;
      q.push_back('{due: edge_no + p_lat, data: inr ? mmem[req_addr] : 16'h0});
    end
    cyc++;
    m_valid = 0;
    if (q.size() > 0 && q[0].due == edge_no) begin
      m_valid = 1; m_data = q[0].data; void'(q.pop_front());
    end
  endtask

  task automatic compare();
    chk("ready",   o_ready, m_ready());
    chk("r_valid", o_valid, m_valid);
    chk("r_data",  o_data,  m_data);
    chk("rd_cnt",  o_rcnt,  m_rcnt);
    chk("wr_cnt",  o_wcnt,  m_wcnt);
    chk("err_conflict", o_ec, m_ec);
    chk("err_range",    o_er, m_er);
  endtask

  task automatic step(logic rd, logic wr, logic [7:0] a, logic [15:0] d,
                      logic c, logic r);
    req_rd = rd; req_wr = wr; req_addr = a; req_w_data = d;
    clr_stat = c; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h0, 16'h0, 0, 0);
  endtask

  // Keep a request up until the model says it was accepted.
  task automatic hold(logic rd, logic wr, logic [7:0] a, logic [15:0] d);
    for (int i = 0; i < 32; i++) begin
      step(rd, wr, a, d, 0, 0);
      if (m_acc) return;
    end
    n_cmp++; n_err++;
    $error("FAIL hold_timeout: observed no accept expected accept");
  endtask

  task automatic rand_run(int n, int amax);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           8'($urandom_range(0, amax)), 16'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", o_ready, 1); chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);   chk("rst_rcnt", o_rcnt, 0);
    chk("rst_wcnt", o_wcnt, 0);   chk("rst_ec", o_ec, 0);
    chk("rst_er", o_er, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; edge_no = 0; cyc = 0;
    m_rcnt = 0; m_wcnt = 0; m_ec = 0; m_er = 0; m_valid = 0; m_data = '0;
    req_rd = 0; req_wr = 0; req_addr = '0; req_w_data = '0;
    clr_stat = 0; rst = 1;
    foreach (mmem[i]) mmem[i] = '0;

    // ---- Config A: DEPTH=24, RD_LAT=3, no stalls, 4-bit counters ----
    sel = 0; p_lat = 3; p_per = 16; p_len = 0; p_depth = 24; p_cmax = 15;
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1);
    chk_reset_vals();
    for (int i = 0; i < 24; i++) hold(0, 1, 8'(i), 16'($urandom));
    step(0, 0, 0, 0, 1, 0);

    hold(0, 1, 8'd5, 16'h0007);
    hold(1, 0, 8'd5, 16'h0);
    idle(1); chk("lat3_early1", o_valid, 0);
    idle(1); chk("lat3_early2", o_valid, 0);
    idle(1); chk("lat3_valid", o_valid, 1); chk("lat3_data", o_data, 16'h0007);
    chk("lat3_wcnt", o_wcnt, 1); chk("lat3_rcnt", o_rcnt, 1);
    idle(1); chk("lat3_single", o_valid, 0);

    step(0, 0, 0, 0, 1, 0);
    hold(1, 1, 8'd9, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin idle(1); chk("conf_no_valid", o_valid, 0); end
    chk("conf_ec", o_ec, 1); chk("conf_wcnt", o_wcnt, 1); chk("conf_rcnt", o_rcnt, 0);
    hold(1, 0, 8'd9, 16'h0); idle(3); chk("conf_mem", o_data, 16'hBEEF);
    step(0, 0, 0, 0, 1, 0);
    chk("clr_ec", o_ec, 0); chk("clr_wcnt", o_wcnt, 0); chk("clr_rcnt", o_rcnt, 0);

    hold(0, 1, 8'd30, 16'h1234); chk("range_er", o_er, 1);
    hold(1, 0, 8'd30, 16'h0); idle(3);
    chk("range_valid", o_valid, 1); chk("range_zero", o_data, 0);
    for (int i = 0; i < 24; i++) hold(1, 0, 8'(i), 16'h0);
    idle(4);

    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) hold(1, 0, 8'($urandom_range(0, 23)), 16'h0);
    idle(4); chk("sat_rcnt", o_rcnt, 15);

    hold(1, 0, 8'd1, 16'h0); hold(1, 0, 8'd2, 16'h0);
    step(0, 0, 0, 0, 0, 1); chk_reset_vals();
    for (int i = 0; i < 5; i++) begin idle(1); chk("rst_drop", o_valid, 0); end

    rand_run(400, 31);

    // ---- Config B: DEPTH=256, RD_LAT=2, stall 2 of every 8 cycles ----
    sel = 1; p_lat = 2; p_per = 8; p_len = 2; p_depth = 256; p_cmax = 65535;
    step(0, 0, 0, 0, 0, 1); chk_reset_vals();
    for (int i = 0; i < 256; i++) hold(0, 1, 8'(i), 16'($urandom));
    for (int i = 0; i < 4; i++) hold(0, 1, 8'(i), 16'(16'h10 + i));

    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      step(k < 4, 0, 8'(k), 16'h0, 0, 0);
      if (k >= 2) begin
        chk("pipe_valid", o_valid, 1); chk("pipe_data", o_data, 16'(16'h10 + k - 2));
      end
    end

    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) step(1, 0, 8'($urandom), 16'h0, 0, 0);
    idle(3); chk("stall_rcnt", o_rcnt, 24);

    rand_run(400, 255);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
